// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_ctrl
// Purpose  : fetch PC owner; issues 16B-aligned I-cache requests and delivers
//            each line realigned to the fetch PC. Option: IFU_MISALIGN_CHECK_EN
// Revision : 1.0
// ============================================================================
module ifu_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         fetch_inst,
    input  logic         mem_stall,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_target,
    output logic         icache_req_valid,
    input  logic         icache_req_ready,
    output logic [63:0]  icache_req_addr,
    input  logic         icache_resp_valid,
    input  logic [127:0] icache_resp_data,
    output logic [127:0] aligned_instr,
    output logic [3:0]   aligned_instr_valid,
    output logic [63:0]  pc,
    output logic         pc_operation_done,
    output logic         fetch_misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [63:0]    fetch_pc_q, fetch_pc_d;
    logic           pending_q, pending_d;
    logic [127:0]   instr_q, instr_d;
    logic [3:0]     valid_q, valid_d;
    logic [63:0]    pc_q, pc_d;
    logic           done_q, done_d;
    logic           fetch_enable;
    logic [1:0]     offset;
    logic [63:0]    target_aligned;

    assign offset         = fetch_pc_q[3:2];
    assign target_aligned = redirect_target & ~64'h3;

`ifdef IFU_MISALIGN_CHECK_EN
    logic park_q, park_d;
    logic misalign_q, misalign_d;
    logic target_misaligned;

    assign target_misaligned = (redirect_target[1:0] != 2'b00);

    // A misaligned redirect parks fetch until an aligned redirect arrives.
    always_comb begin
        park_d     = park_q;
        misalign_d = 1'b0;
        if (redirect_valid) begin
            park_d     = target_misaligned;
            misalign_d = target_misaligned;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            park_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            park_q     <= park_d;
            misalign_q <= misalign_d;
        end
    end

    assign fetch_enable   = !park_q;
    assign fetch_misalign = misalign_q;
`else
    assign fetch_enable   = 1'b1;
    assign fetch_misalign = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pending_d  = pending_q;
        instr_d    = instr_q;
        valid_d    = 4'b0000;
        pc_d       = pc_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_enable && (fetch_inst || pending_q)) begin
                    if (!mem_stall) begin
                        state_d   = REQ;
                        pending_d = 1'b0;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (fetch_inst) pending_d = 1'b1;
                if (icache_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (fetch_inst) pending_d = 1'b1;
                if (icache_resp_valid) begin
                    instr_d    = icache_resp_data >> {offset, 5'b00000};
                    valid_d    = 4'b1111 >> offset;
                    pc_d       = fetch_pc_q;
                    done_d     = 1'b1;
                    fetch_pc_d = {fetch_pc_q[63:4] + 60'd1, 4'b0000};
                    state_d    = IDLE;
                end
            end
            DROP: begin
                if (fetch_inst) pending_d = 1'b1;
                if (icache_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything, including a same-cycle delivery.
        if (redirect_valid) begin
            fetch_pc_d = target_aligned;
            pending_d  = 1'b0;
            instr_d    = instr_q;
            valid_d    = 4'b0000;
            pc_d       = pc_q;
            done_d     = 1'b0;
            case (state_q)
                REQ:     state_d = icache_req_ready  ? DROP : IDLE;
                WAIT:    state_d = icache_resp_valid ? IDLE : DROP;
                DROP:    state_d = icache_resp_valid ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pending_q  <= 1'b0;
            instr_q    <= '0;
            valid_q    <= 4'b0000;
            pc_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            done_q     <= done_d;
        end
    end

    assign icache_req_valid    = (state_q == REQ);
    assign icache_req_addr     = {fetch_pc_q[63:4], 4'b0000};
    assign aligned_instr       = instr_q;
    assign aligned_instr_valid = valid_q;
    assign pc                  = pc_q;
    assign pc_operation_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// tb_ifu_fetch_ctrl: directed stimulus with queued expectations checked by
// independent request and delivery monitors.
module tb_ifu_fetch_ctrl;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         fetch_inst = 1'b0;
    logic         mem_stall = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [63:0]  redirect_target = '0;
    logic         icache_req_valid;
    logic         icache_req_ready = 1'b1;
    logic [63:0]  icache_req_addr;
    logic         icache_resp_valid = 1'b0;
    logic [127:0] icache_resp_data = '0;
    logic [127:0] aligned_instr;
    logic [3:0]   aligned_instr_valid;
    logic [63:0]  pc;
    logic         pc_operation_done;
    logic         fetch_misalign;

    ifu_fetch_ctrl dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .fetch_inst          (fetch_inst),
        .mem_stall           (mem_stall),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .icache_req_valid    (icache_req_valid),
        .icache_req_ready    (icache_req_ready),
        .icache_req_addr     (icache_req_addr),
        .icache_resp_valid   (icache_resp_valid),
        .icache_resp_data    (icache_resp_data),
        .aligned_instr       (aligned_instr),
        .aligned_instr_valid (aligned_instr_valid),
        .pc                  (pc),
        .pc_operation_done   (pc_operation_done),
        .fetch_misalign      (fetch_misalign)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [127:0] instr;
        logic [3:0]   valid;
        logic [63:0]  pc;
        logic [31:0]  cyc;
    } deliv_t;

    localparam logic [31:0] WA = 32'hAAAA_0001;
    localparam logic [31:0] WB = 32'hBBBB_0002;
    localparam logic [31:0] WC = 32'hCCCC_0003;
    localparam logic [31:0] WD = 32'hDDDD_0004;
    localparam logic [127:0] LINE = {WD, WC, WB, WA};

    logic [63:0] req_q[$];
    deliv_t      del_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request monitor: address must match the queued expectation every cycle valid is high.
    always @(negedge clock) begin
        if (reset_n && icache_req_valid) begin
            checks++;
            if (req_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_req: got addr %h expected no request", icache_req_addr);
            end else begin
                if (icache_req_addr !== req_q[0]) begin
                    failures++;
                    $display("FAIL req_addr: got %h expected %h", icache_req_addr, req_q[0]);
                end
                if (icache_req_ready) void'(req_q.pop_front());
            end
        end
    end

    // Delivery monitor: content, pc, done strobe and exact cycle of each line.
    always @(negedge clock) begin
        if (aligned_instr_valid != 4'b0000) begin
            checks++;
            if (del_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_delivery: got valid %b pc %h expected none", aligned_instr_valid, pc);
            end else begin
                deliv_t e;
                e = del_q.pop_front();
                if (aligned_instr !== e.instr || aligned_instr_valid !== e.valid ||
                    pc !== e.pc || pc_operation_done !== 1'b1 || cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL delivery: got instr %h valid %b pc %h done %b cyc %0d expected instr %h valid %b pc %h done 1 cyc %0d",
                             aligned_instr, aligned_instr_valid, pc, pc_operation_done, cyc,
                             e.instr, e.valid, e.pc, e.cyc);
                end
            end
        end else if (pc_operation_done) begin
            checks++;
            failures++;
            $display("FAIL done_without_valid: got done 1 expected 0");
        end
    end

    task automatic wait_accept(output bit ok);
        bit done;
        done = 0;
        ok   = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (icache_req_valid && icache_req_ready) begin
                done = 1;
                ok   = 1;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no accepted request expected one within 20 cycles");
        end
    endtask

    task automatic respond(input logic [127:0] data, input logic [127:0] exp_instr,
                           input logic [3:0] exp_valid, input logic [63:0] exp_pc, input int delay);
        deliv_t e;
        repeat (delay) tick();
        icache_resp_valid = 1'b1;
        icache_resp_data  = data;
        e.instr = exp_instr;
        e.valid = exp_valid;
        e.pc    = exp_pc;
        e.cyc   = cyc + 1;
        del_q.push_back(e);
        tick();
        icache_resp_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_fetch(input logic [63:0] exp_addr, input logic [127:0] exp_instr,
                            input logic [3:0] exp_valid, input logic [63:0] exp_pc, input int delay);
        bit ok;
        req_q.push_back(exp_addr);
        fetch_inst = 1'b1;
        tick();
        fetch_inst = 1'b0;
        wait_accept(ok);
        if (ok) respond(LINE, exp_instr, exp_valid, exp_pc, delay);
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid  = 1'b1;
        redirect_target = target;
        tick();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        bit ok;
        tick();
        chk("reset_req_valid", {127'b0, icache_req_valid}, 128'd0);
        chk("reset_instr", aligned_instr, 128'd0);
        chk("reset_valid", {124'b0, aligned_instr_valid}, 128'd0);
        chk("reset_pc", {64'b0, pc}, 128'd0);
        chk("reset_done", {127'b0, pc_operation_done}, 128'd0);
        chk("reset_misalign", {127'b0, fetch_misalign}, 128'd0);
        reset_n = 1'b1;
        tick();

        // Sequential fetches from reset PC
        do_fetch(64'h8000_0000, LINE, 4'b1111, 64'h8000_0000, 2);
        do_fetch(64'h8000_0010, LINE, 4'b1111, 64'h8000_0010, 1);

        // Redirect into the middle of a line
        redirect(64'h8000_0108);
        do_fetch(64'h8000_0100, {64'b0, WD, WC}, 4'b0011, 64'h8000_0108, 1);
        do_fetch(64'h8000_0110, LINE, 4'b1111, 64'h8000_0110, 0);

        // Redirect while waiting: the late response must be dropped
        req_q.push_back(64'h8000_0120);
        fetch_inst = 1'b1;
        tick();
        fetch_inst = 1'b0;
        wait_accept(ok);
        tick();
        redirect(64'h8000_0200);
        tick();
        icache_resp_valid = 1'b1;
        icache_resp_data  = LINE;
        tick();
        icache_resp_valid = 1'b0;
        repeat (3) tick();
        do_fetch(64'h8000_0200, LINE, 4'b1111, 64'h8000_0200, 1);

        // Redirect coincident with the response
        req_q.push_back(64'h8000_0210);
        fetch_inst = 1'b1;
        tick();
        fetch_inst = 1'b0;
        wait_accept(ok);
        icache_resp_valid = 1'b1;
        icache_resp_data  = LINE;
        redirect(64'h8000_0304);
        icache_resp_valid = 1'b0;
        repeat (3) tick();
        do_fetch(64'h8000_0300, {32'b0, WD, WC, WB}, 4'b0111, 64'h8000_0304, 0);

        // mem_stall blocks launch; request address held while ready is low
        mem_stall  = 1'b1;
        fetch_inst = 1'b1;
        repeat (5) tick();
        chk("stall_no_req", {127'b0, icache_req_valid}, 128'd0);
        req_q.push_back(64'h8000_0310);
        icache_req_ready = 1'b0;
        mem_stall = 1'b0;
        tick();
        fetch_inst = 1'b0;
        chk("unstall_req", {127'b0, icache_req_valid}, 128'd1);
        repeat (3) tick();
        icache_req_ready = 1'b1;
        wait_accept(ok);
        if (ok) respond(LINE, LINE, 4'b1111, 64'h8000_0310, 1);

        // 64-bit PC wrap
        redirect(64'hFFFF_FFFF_FFFF_FFF4);
        do_fetch(64'hFFFF_FFFF_FFFF_FFF0, {32'b0, WD, WC, WB}, 4'b0111, 64'hFFFF_FFFF_FFFF_FFF4, 1);
        do_fetch(64'h0000_0000_0000_0000, LINE, 4'b1111, 64'h0, 1);

`ifdef IFU_MISALIGN_CHECK_EN
        redirect(64'h8000_0002);
        chk("misalign_pulse", {127'b0, fetch_misalign}, 128'd1);
        tick();
        chk("misalign_clear", {127'b0, fetch_misalign}, 128'd0);
        fetch_inst = 1'b1;
        tick();
        fetch_inst = 1'b0;
        repeat (6) tick();
        redirect(64'h8000_0000);
        chk("aligned_no_misalign", {127'b0, fetch_misalign}, 128'd0);
        do_fetch(64'h8000_0000, LINE, 4'b1111, 64'h8000_0000, 1);
`else
        redirect(64'h8000_0402);
        chk("misalign_tied_0", {127'b0, fetch_misalign}, 128'd0);
        do_fetch(64'h8000_0400, LINE, 4'b1111, 64'h8000_0400, 1);
`endif

        repeat (5) tick();
        chk("req_queue_drained", 128'(req_q.size()), 128'd0);
        chk("deliv_queue_drained", 128'(del_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
